// File: rtl/iob_cache_pkg.sv
// iob_cache_pkg
// Definitions shared by the cache read channel, the miss controller and
// the line fill buffer:
//   - fill_state_t : line fill FSM encoding (IDLE=0, FILL=1, COMMIT=2).
//   - line2be_w()  : log2(back-end beats per cache line).
package iob_cache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_COMMIT = 2'd2
  } fill_state_t;

  // A result of 0 means one back-end beat carries the whole line.
  function automatic int line2be_w(input int word_offset_w,
                                   input int be_data_w,
                                   input int data_w);
    return word_offset_w - $clog2(be_data_w / data_w);
  endfunction

endpackage

// File: rtl/iob_cache_line_fill_buffer_if.sv
// iob_cache_line_fill_buffer_if
// Groups the signals around the line fill buffer: the fill request from
// the miss controller, the beat stream from the AXI read channel, and the
// line write / word forward toward the data memory and front-end.
//   slave  : the fill buffer (consumes *_i, drives *_o)
//   master : the surrounding cache logic
interface iob_cache_line_fill_buffer_if
  import iob_cache_pkg::*;
#(
  parameter int DATA_W        = 32,
  parameter int BE_DATA_W     = 32,
  parameter int WORD_OFFSET_W = 3
) ();

  localparam int LINE2BE_W  = line2be_w(WORD_OFFSET_W, BE_DATA_W, DATA_W);
  localparam int BEAT_IDX_W = (LINE2BE_W > 0) ? LINE2BE_W : 1;
  localparam int LINE_W     = (2**WORD_OFFSET_W) * DATA_W;

  logic                     fill_start_i;
  logic [WORD_OFFSET_W-1:0] req_word_i;
  logic                     replace_i;
  logic                     read_valid_i;
  logic [BEAT_IDX_W-1:0]    read_addr_i;
  logic [BE_DATA_W-1:0]     read_rdata_i;
  logic                     busy_o;
  logic                     line_we_o;
  logic [LINE_W-1:0]        line_wdata_o;
  logic                     fwd_valid_o;
  logic [DATA_W-1:0]        fwd_rdata_o;
  logic                     incomplete_o;

  modport master (
    output fill_start_i, req_word_i, replace_i, read_valid_i, read_addr_i, read_rdata_i,
    input  busy_o, line_we_o, line_wdata_o, fwd_valid_o, fwd_rdata_o, incomplete_o
  );

  modport slave (
    input  fill_start_i, req_word_i, replace_i, read_valid_i, read_addr_i, read_rdata_i,
    output busy_o, line_we_o, line_wdata_o, fwd_valid_o, fwd_rdata_o, incomplete_o
  );

endinterface

// File: rtl/iob_cache_line_fill_buffer.sv
// iob_cache_line_fill_buffer
// Assembles back-end beats of a line replacement into a line-wide register
// and, once the read channel releases replace, writes the whole line to the
// data memory in one cycle while forwarding the requested word.
// Ports:
//   clk_i   : clock
//   reset_i : asynchronous active-high reset
//   bus     : iob_cache_line_fill_buffer_if.slave
//             fill_start_i/req_word_i    fill request (IDLE only)
//             replace_i/read_valid_i/read_addr_i/read_rdata_i  beat stream
//             busy_o                     FSM not in IDLE
//             line_we_o/line_wdata_o     one-cycle line write
//             fwd_valid_o/fwd_rdata_o    requested word, same cycle
//             incomplete_o               some beat slot never written
module iob_cache_line_fill_buffer
  import iob_cache_pkg::*;
#(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int BE_DATA_W     = 32,
  parameter int WORD_OFFSET_W = 3
) (
  input logic                           clk_i,
  input logic                           reset_i,
  iob_cache_line_fill_buffer_if.slave   bus
);

  localparam int LINE2BE_W  = line2be_w(WORD_OFFSET_W, BE_DATA_W, DATA_W);
  localparam int BEAT_IDX_W = (LINE2BE_W > 0) ? LINE2BE_W : 1;
  localparam int N_BEATS    = 2**LINE2BE_W;
  localparam int N_WORDS    = 2**WORD_OFFSET_W;
  localparam int LINE_W     = N_WORDS * DATA_W;

  // Elaboration-time sanity check of the geometry.
  if ((BE_DATA_W % DATA_W) != 0 || LINE2BE_W < 0 || ADDR_W < WORD_OFFSET_W) begin : g_bad_cfg
    $error("iob_cache_line_fill_buffer: inconsistent width parameters");
  end

  fill_state_t              state;
  logic [LINE_W-1:0]        buffer;
  logic [N_BEATS-1:0]       mask;
  logic [N_BEATS-1:0]       beat_bit;
  logic                     seen_replace;
  logic [WORD_OFFSET_W-1:0] req_word;
  logic [BEAT_IDX_W-1:0]    beat_idx;
  logic                     line_we;
  logic                     fwd_valid;
  logic                     incomplete;
  logic [DATA_W-1:0]        fwd_rdata;

  // With a single beat per line the address input carries no information.
  assign beat_idx = (LINE2BE_W == 0) ? '0 : bus.read_addr_i;

  always_comb begin
    beat_bit = '0;
    for (int b = 0; b < N_BEATS; b++) begin
      beat_bit[b] = bus.read_valid_i && (beat_idx == BEAT_IDX_W'(b));
    end
  end

  // Control FSM. Commit strobes are registered on the FILL->COMMIT edge so
  // they are high for exactly the COMMIT cycle. The mask used for
  // incomplete includes a beat arriving on that same edge.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state        <= ST_IDLE;
      mask         <= '0;
      seen_replace <= 1'b0;
      req_word     <= '0;
      line_we      <= 1'b0;
      fwd_valid    <= 1'b0;
      incomplete   <= 1'b0;
    end else begin
      line_we    <= 1'b0;
      fwd_valid  <= 1'b0;
      incomplete <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.fill_start_i) begin
            req_word     <= bus.req_word_i;
            mask         <= '0;
            seen_replace <= 1'b0;
            state        <= ST_FILL;
          end
        end
        ST_FILL: begin
          mask <= mask | beat_bit;
          // replace low before it was ever seen high means the read
          // channel has not started yet, not that the burst ended.
          if (bus.replace_i) begin
            seen_replace <= 1'b1;
          end else if (seen_replace) begin
            state      <= ST_COMMIT;
            line_we    <= 1'b1;
            fwd_valid  <= 1'b1;
            incomplete <= ~&(mask | beat_bit);
          end
        end
        ST_COMMIT: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Line buffer: a repeated beat index simply overwrites its slot, which
  // discards data from a failed, re-issued burst.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      buffer <= '0;
    end else if (state == ST_FILL && bus.read_valid_i) begin
      for (int b = 0; b < N_BEATS; b++) begin
        if (beat_idx == BEAT_IDX_W'(b)) begin
          buffer[b*BE_DATA_W +: BE_DATA_W] <= bus.read_rdata_i;
        end
      end
    end
  end

  always_comb begin
    fwd_rdata = '0;
    for (int w = 0; w < N_WORDS; w++) begin
      if (req_word == WORD_OFFSET_W'(w)) begin
        fwd_rdata = buffer[w*DATA_W +: DATA_W];
      end
    end
  end

  assign bus.busy_o       = (state != ST_IDLE);
  assign bus.line_we_o    = line_we;
  assign bus.line_wdata_o = buffer;
  assign bus.fwd_valid_o  = fwd_valid;
  assign bus.fwd_rdata_o  = fwd_rdata;
  assign bus.incomplete_o = incomplete;

endmodule

// File: tb/tb_iob_cache_line_fill_buffer.sv
// Testbench for iob_cache_line_fill_buffer: a 4-beat configuration
// (64-bit beats) driven from a vector table plus hand-written retry and
// reset sequences, and a single-beat configuration (256-bit beats).
module tb_iob_cache_line_fill_buffer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks    = 0;
  int failures  = 0;
  int commits_a = 0;
  int commits_b = 0;

  iob_cache_line_fill_buffer_if #(.DATA_W(32), .BE_DATA_W(64),  .WORD_OFFSET_W(3)) ifa ();
  iob_cache_line_fill_buffer_if #(.DATA_W(32), .BE_DATA_W(256), .WORD_OFFSET_W(3)) ifb ();

  iob_cache_line_fill_buffer #(
    .ADDR_W(32), .DATA_W(32), .BE_DATA_W(64), .WORD_OFFSET_W(3)
  ) dut_a (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (ifa)
  );

  iob_cache_line_fill_buffer #(
    .ADDR_W(32), .DATA_W(32), .BE_DATA_W(256), .WORD_OFFSET_W(3)
  ) dut_b (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (ifb)
  );

  always @(negedge clk) begin
    if (ifa.line_we_o === 1'b1) commits_a <= commits_a + 1;
    if (ifb.line_we_o === 1'b1) commits_b <= commits_b + 1;
  end

  localparam logic [255:0] LINE_A = 256'h00000007_00000006_00000005_00000004_00000003_00000002_00000001_00000000;
  localparam logic [255:0] LINE_B = 256'h00000017_00000016_00000015_00000014_00000013_00000012_00000011_00000010;
  localparam logic [255:0] LINE_C = 256'h000000C7_000000C6_000000C5_000000C4_000000C3_000000C2_000000C1_000000C0;
  localparam logic [255:0] LINE_D = 256'h000000D7_000000D6_000000D5_000000D4_000000D3_000000D2_000000D1_000000D0;
  // LINE_D with beat 2 missing: words 4,5 keep the previous fill (LINE_C).
  localparam logic [255:0] LINE_DM = 256'h000000D7_000000D6_000000C5_000000C4_000000D3_000000D2_000000D1_000000D0;
  localparam logic [255:0] LINE_E = 256'hE7E7E7E7_E6E6E6E6_E5E5E5E5_E4E4E4E4_E3E3E3E3_E2E2E2E2_E1E1E1E1_E0E0E0E0;
  localparam logic [255:0] LINE_AA = {8{32'hAAAAAAAA}};

  typedef struct packed {
    logic [2:0]   req;
    logic [3:0]   gap;
    logic [3:0]   send;
    logic [255:0] data;
    logic [255:0] exp_line;
    logic [31:0]  exp_fwd;
    logic         exp_inc;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic start_a(input logic [2:0] req);
    ifa.fill_start_i = 1'b1;
    ifa.req_word_i   = req;
    @(negedge clk);
    ifa.fill_start_i = 1'b0;
    chk("busy_after_start", 256'(ifa.busy_o), 256'd1);
  endtask

  task automatic beats_a(input logic [255:0] data, input logic [3:0] send, input int gap);
    for (int b = 0; b < 4; b++) begin
      if (send[b]) begin
        ifa.read_valid_i = 1'b1;
        ifa.read_addr_i  = 2'(b);
        ifa.read_rdata_i = data[b*64 +: 64];
        @(negedge clk);
        ifa.read_valid_i = 1'b0;
        repeat (gap) @(negedge clk);
      end
    end
  endtask

  // Drops replace, then checks the commit cycle and the cycle after it.
  task automatic commit_a(input string name, input logic [255:0] exp_line,
                          input logic [31:0] exp_fwd, input logic exp_inc, input int c0);
    ifa.replace_i = 1'b0;
    @(negedge clk);
    chk({name, "_line_we"},    256'(ifa.line_we_o),    256'd1);
    chk({name, "_fwd_valid"},  256'(ifa.fwd_valid_o),  256'd1);
    chk({name, "_incomplete"}, 256'(ifa.incomplete_o), 256'(exp_inc));
    chk({name, "_line"},       ifa.line_wdata_o,       exp_line);
    chk({name, "_fwd"},        256'(ifa.fwd_rdata_o),  256'(exp_fwd));
    @(negedge clk);
    chk({name, "_we_drop"},    256'(ifa.line_we_o),    256'd0);
    chk({name, "_idle"},       256'(ifa.busy_o),       256'd0);
    chk({name, "_commits"},    256'(commits_a - c0),   256'd1);
  endtask

  task automatic idle_inputs();
    ifa.fill_start_i = 1'b0; ifa.req_word_i = '0; ifa.replace_i = 1'b0;
    ifa.read_valid_i = 1'b0; ifa.read_addr_i = '0; ifa.read_rdata_i = '0;
    ifb.fill_start_i = 1'b0; ifb.req_word_i = '0; ifb.replace_i = 1'b0;
    ifb.read_valid_i = 1'b0; ifb.read_addr_i = '0; ifb.read_rdata_i = '0;
  endtask

  initial begin
    int c0;
    vecs[0] = '{req: 3'd5, gap: 4'd0, send: 4'b1111, data: LINE_A, exp_line: LINE_A,  exp_fwd: 32'h5,  exp_inc: 1'b0};
    vecs[1] = '{req: 3'd5, gap: 4'd3, send: 4'b1111, data: LINE_A, exp_line: LINE_A,  exp_fwd: 32'h5,  exp_inc: 1'b0};
    vecs[2] = '{req: 3'd0, gap: 4'd0, send: 4'b1111, data: LINE_B, exp_line: LINE_B,  exp_fwd: 32'h10, exp_inc: 1'b0};
    vecs[3] = '{req: 3'd7, gap: 4'd1, send: 4'b1111, data: LINE_C, exp_line: LINE_C,  exp_fwd: 32'hC7, exp_inc: 1'b0};
    vecs[4] = '{req: 3'd4, gap: 4'd0, send: 4'b1011, data: LINE_D, exp_line: LINE_DM, exp_fwd: 32'hC4, exp_inc: 1'b1};

    idle_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy",       256'(ifa.busy_o),       256'd0);
    chk("rst_line_we",    256'(ifa.line_we_o),    256'd0);
    chk("rst_fwd_valid",  256'(ifa.fwd_valid_o),  256'd0);
    chk("rst_incomplete", 256'(ifa.incomplete_o), 256'd0);
    chk("rst_line",       ifa.line_wdata_o,       256'd0);
    chk("rst_busy_b",     256'(ifb.busy_o),       256'd0);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven fills; each one starts in the cycle right after the
    // previous commit, exercising back-to-back acceptance.
    for (int i = 0; i < 5; i++) begin
      c0 = commits_a;
      start_a(vecs[i].req);
      ifa.replace_i = 1'b1;
      beats_a(vecs[i].data, vecs[i].send, int'(vecs[i].gap));
      commit_a($sformatf("vec%0d", i), vecs[i].exp_line, vecs[i].exp_fwd, vecs[i].exp_inc, c0);
    end

    // Retry: read channel idle for 2 cycles, failed burst, re-issued burst.
    c0 = commits_a;
    start_a(3'd3);
    repeat (2) @(negedge clk);
    chk("retry_wait_busy",    256'(ifa.busy_o), 256'd1);
    chk("retry_wait_commits", 256'(commits_a - c0), 256'd0);
    ifa.replace_i = 1'b1;
    beats_a(LINE_AA, 4'b1111, 0);
    repeat (2) @(negedge clk);
    chk("retry_mid_commits", 256'(commits_a - c0), 256'd0);
    chk("retry_mid_busy",    256'(ifa.busy_o), 256'd1);
    beats_a(LINE_A, 4'b1111, 0);
    commit_a("retry", LINE_A, 32'h3, 1'b0, c0);

    // Reset after beat 1 of a fill.
    c0 = commits_a;
    start_a(3'd1);
    ifa.replace_i = 1'b1;
    beats_a(LINE_D, 4'b0011, 0);
    rst = 1'b1;
    #1;
    chk("rstmid_busy_async", 256'(ifa.busy_o), 256'd0);
    @(negedge clk);
    chk("rstmid_busy",    256'(ifa.busy_o),      256'd0);
    chk("rstmid_line_we", 256'(ifa.line_we_o),   256'd0);
    chk("rstmid_line",    ifa.line_wdata_o,      256'd0);
    chk("rstmid_fwd",     256'(ifa.fwd_rdata_o), 256'd0);
    rst = 1'b0;
    ifa.replace_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("rstmid_commits", 256'(commits_a - c0), 256'd0);
    start_a(3'd6);
    ifa.replace_i = 1'b1;
    beats_a(LINE_B, 4'b1111, 0);
    commit_a("post_reset", LINE_B, 32'h16, 1'b0, c0);

    // Single-beat configuration; extra starts in FILL and COMMIT are ignored.
    c0 = commits_b;
    ifb.fill_start_i = 1'b1;
    ifb.req_word_i   = 3'd7;
    @(negedge clk);
    chk("b_busy_start", 256'(ifb.busy_o), 256'd1);
    ifb.replace_i    = 1'b1;
    ifb.fill_start_i = 1'b1;
    ifb.req_word_i   = 3'd2;
    ifb.read_valid_i = 1'b1;
    ifb.read_addr_i  = 1'b1;
    ifb.read_rdata_i = LINE_E;
    @(negedge clk);
    ifb.fill_start_i = 1'b0;
    ifb.read_valid_i = 1'b0;
    ifb.read_addr_i  = 1'b0;
    @(negedge clk);
    chk("b_busy_fill", 256'(ifb.busy_o), 256'd1);
    ifb.replace_i = 1'b0;
    @(negedge clk);
    chk("b_line_we",    256'(ifb.line_we_o),    256'd1);
    chk("b_fwd_valid",  256'(ifb.fwd_valid_o),  256'd1);
    chk("b_incomplete", 256'(ifb.incomplete_o), 256'd0);
    chk("b_line",       ifb.line_wdata_o,       LINE_E);
    chk("b_fwd",        256'(ifb.fwd_rdata_o),  256'(32'hE7E7E7E7));
    ifb.fill_start_i = 1'b1;
    ifb.req_word_i   = 3'd1;
    @(negedge clk);
    ifb.fill_start_i = 1'b0;
    chk("b_we_drop", 256'(ifb.line_we_o), 256'd0);
    chk("b_idle",    256'(ifb.busy_o),    256'd0);
    chk("b_commits", 256'(commits_b - c0), 256'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/iob_cache_line_fill_buffer.md
# iob_cache_line_fill_buffer

Line-assembly stage directly downstream of the cache's AXI read channel. Captures the back-end beats the read channel delivers during a line replacement and holds them in a line-wide register. When the read channel drops `replace`, commits the complete line to the data memory in one write, and forwards the originally requested word to the front-end in the same cycle. Because nothing commits until the read channel releases `replace`, beats from a burst the slave failed and the read channel re-issued are overwritten, never committed.

## Interface
Parameters:
- `ADDR_W`, 32, front-end byte-address width (informative only).
- `DATA_W`, 32, front-end word width.
- `BE_DATA_W`, 32, back-end beat width; integer multiple of `DATA_W`.
- `WORD_OFFSET_W`, 3, log2(words per line).
- `LINE2BE_W`, `WORD_OFFSET_W - $clog2(BE_DATA_W/DATA_W)`, log2(beats per line); derived, never overridden. 0 means one beat per line.
- `LINE_W`, `(2**WORD_OFFSET_W)*DATA_W`, derived line width.

Ports:
- `clk_i`, in, 1, clock.
- `reset_i`, in, 1, asynchronous active-high reset.
- `fill_start_i`, in, 1, one-cycle pulse from the miss controller that starts a fill.
- `req_word_i`, in, `WORD_OFFSET_W`, word offset of the missing access; sampled with `fill_start_i`.
- `replace_i`, in, 1, read channel busy; high from request through end-of-burst delay.
- `read_valid_i`, in, 1, beat valid from the read channel.
- `read_addr_i`, in, max(`LINE2BE_W`,1), beat index within the line; ignored when `LINE2BE_W`=0.
- `read_rdata_i`, in, `BE_DATA_W`, beat data.
- `busy_o`, out, 1, high in any state except IDLE.
- `line_we_o`, out, 1, one-cycle data-memory line write strobe.
- `line_wdata_o`, out, `LINE_W`, assembled line, driven straight from the buffer register.
- `fwd_valid_o`, out, 1, one-cycle pulse that coincides with `line_we_o`.
- `fwd_rdata_o`, out, `DATA_W`, equal to `line_wdata_o[req_word*DATA_W +: DATA_W]`.
- `incomplete_o`, out, 1, pulse with `line_we_o` when any beat-mask bit is 0 at commit.

## Operation
State machine: IDLE, FILL, COMMIT.
- **IDLE**
  - `fill_start_i` latches `req_word_i`, clears the beat mask and `seen_replace`, then moves to FILL.
  - In FILL and COMMIT, `fill_start_i` is ignored.
- **FILL**
  - On `read_valid_i`: write `read_rdata_i` into beat slot `read_addr_i` (slot 0 when `LINE2BE_W`=0) and set that mask bit.
  - A repeated beat index overwrites the slot; this is the retry case.
  - `replace_i`=1 sets `seen_replace`.
  - `replace_i`=0 with `seen_replace`=1 moves to COMMIT.
  - `replace_i`=0 with `seen_replace`=0 stays in FILL, which covers the read channel not yet having left idle.
- **COMMIT**
  - `line_we_o`=1 and `fwd_valid_o`=1; `incomplete_o`=!(&mask).
  - Next state IDLE, unconditionally.
- Beat slot b occupies `line_wdata_o[b*BE_DATA_W +: BE_DATA_W]`.
- The forward word index is a `WORD_OFFSET_W`-bit unsigned select; no wrap logic is needed.
- Reset, including mid-fill:
  - State goes to IDLE; mask, `seen_replace` and `req_word` are cleared.
  - `line_we_o`, `fwd_valid_o`, `incomplete_o` and `busy_o` are 0.
  - The buffer contents are cleared to 0.

## Timing
- Beat capture: the buffer slot is updated at the edge where `read_valid_i`=1 in FILL. No back-pressure is applied; the read channel asserts `rready` unconditionally.
- Commit latency: if edge N samples `replace_i`=0 after `seen_replace`, then `line_we_o`, `fwd_valid_o` and `incomplete_o` are high for exactly the cycle following edge N.
- Back-to-back fills: a `fill_start_i` in the cycle after COMMIT (state IDLE) is accepted, so the minimum fill-to-fill gap is one cycle.
- All outputs are decoded from registered state only; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `iob_cache_pkg` holds:
  - the state encoding (IDLE=0, FILL=1, COMMIT=2, 2 bits);
  - the `LINE2BE_W` derivation as a function, so the read channel, this block and the miss controller share one definition.
- No sub-module. The buffer is a flat `LINE_W` register with a per-beat write enable, plus a `2**LINE2BE_W`-bit mask.

## Test plan
Bench configuration: `DATA_W`=32, `BE_DATA_W`=64, `WORD_OFFSET_W`=3, so `LINE2BE_W`=2 (4 beats). The last case uses `BE_DATA_W`=256, so `LINE2BE_W`=0.
- **Normal fill:** `fill_start` with `req_word`=5; `replace` high; beats 0..3 = 0x0000000100000000, 0x0000000300000002, 0x0000000500000004, 0x0000000700000006; `replace` falls. Expect one `line_we`, `line_wdata` words 0..7 = 0..7, `fwd_rdata`=5, `incomplete`=0.
- **Gapped beats:** the same beats with 3 idle cycles between each. Expect an identical commit exactly one cycle after `replace` falls.
- **Retry:** first burst beats 0..3 = 0xAA..; `replace` stays high; second burst beats 0..3 = 0x0000000100000000, 0x0000000300000002, 0x0000000500000004, 0x0000000700000006 (as in the normal fill). Expect a single commit carrying that second-burst data and no commit between the bursts.
- **Missing beat:** only beats 0, 1 and 3 arrive before `replace` falls. Expect a commit with `incomplete`=1.
- **Reset mid-fill:** assert `reset_i` after beat 1. Expect `busy`=0, no commit, and `line_wdata`=0. A new fill after reset commits correctly.
- **Single-beat config and ignored start:** with `LINE2BE_W`=0, send one beat; a second `fill_start` arriving during FILL is ignored. Expect one commit; `req_word`=7 forwards bits [255:224].
